rf_host_access_seq: RTL and testbench
=====================================

// Module: rf_host_access_seq
// PURPOSE
//  Sequences host (debug) reads/writes of the core register file through a req/ack handshake.
//  Shares read port B and the write port with the pipeline; the core always has priority.
//  Forces a core hold when the host has been starved for MAX_WAIT cycles.
//  Sits between the host interface and the register-file port muxes.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    6   host/core register address width (host space r0..r63)
//  NUM_REGS  32  registers physically in the file; addresses >= NUM_REGS are errors
//  MAX_WAIT  8   ungranted ARB cycles before core_hold asserts (1..255)
// PORTS
//  clk          in   1       clock
//  rst_a        in   1       reset, asynchronous, active-low
//  h_req        in   1       host request; held high until h_ack
//  h_write      in   1       1=write, 0=read; sampled with h_req in IDLE
//  h_addr       in   ADDR_W  host register address
//  h_wdata      in   DATA_W  host write data
//  h_ack        out  1       one-cycle completion pulse
//  h_err        out  1       valid with h_ack: address out of range, no RAM access
//  h_rdata      out  DATA_W  read result, held until next read completes
//  core_rd_b    in   1       pipeline uses read port B this cycle
//  core_we      in   1       pipeline writes the register file this cycle
//  core_wba     in   ADDR_W  pipeline write address
//  core_wbdata  in   DATA_W  pipeline write data
//  rf_qb        in   DATA_W  register file port-B read data (sync, 1-cycle latency)
//  rf_host_b    out  1       select host address onto port B
//  rf_host_w    out  1       select host address/data onto write port, write enable
//  rf_addr      out  ADDR_W  host address to port muxes (latched request address)
//  rf_wdata     out  DATA_W  host write data (latched)
//  core_hold    out  1       request pipeline stall to free ports
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, wait counter=0; rst_a mid-operation aborts with no ack.
//  FSM: IDLE, ARB, RD_CAPT, DONE.
//  IDLE: h_req=1 -> latch h_write/h_addr/h_wdata into rf_addr/rf_wdata; counter=0;
//    h_addr>=NUM_REGS -> DONE with err flag set, else ARB.
//  ARB read: grant when core_rd_b=0 -> rf_host_b=1 (combinational) this cycle, go RD_CAPT.
//  ARB write: grant when core_we=0 -> rf_host_w=1 (combinational) this cycle, go DONE.
//  ARB no grant: counter++ (saturating); counter==MAX_WAIT -> core_hold=1 from next cycle.
//  core_hold registered; drops the cycle after the grant cycle; never asserted outside ARB.
//  Coherency: core_we=1 with core_wba==rf_addr in the read grant cycle -> capture
//    core_wbdata in RD_CAPT instead of rf_qb (RAM not write-through).
//  RD_CAPT: h_rdata<=rf_qb (or bypass value); go DONE.
//  DONE: h_ack=1 one cycle; h_err=1 only for range errors; go IDLE.
//  h_req level in DONE ignored; next request accepted in IDLE the following cycle,
//    so back-to-back reads complete every 4 cycles with no contention.
//  Latency with free ports: read req->ack 3 cycles, write 2 cycles, error 1 cycle.
//  h_req dropping before h_ack: protocol violation, request still completes.
//  h_rdata unchanged on writes and errors.
// TESTING
//  Read r5, ports free, rf_qb=0xDEADBEEF -> rf_host_b 1 cycle, h_ack 3 cycles after req, h_rdata=0xDEADBEEF.
//  Write r7=0x12345678 with core_we=1 for 3 cycles -> rf_host_w on 4th ARB cycle, h_ack next cycle.
//  Read with core_rd_b held 1, MAX_WAIT=8 -> core_hold rises after 8 ungranted cycles; release -> grant, hold drops.
//  Read addr 40 (NUM_REGS=32) -> h_ack+h_err next cycle, no rf_host_b/w, h_rdata unchanged.
//  Read r3 while core writes r3=0xCAFE0001 in grant cycle, rf_qb stale -> h_rdata=0xCAFE0001.
//  Assert rst_a low during ARB with core_hold=1 -> all outputs 0 immediately, no h_ack after release.

Source files
------------

// File: rtl/rf_host_access_seq.sv
// Host (debug) access sequencer for the core register file: arbitrates port B and the write
// port against the pipeline, bypasses same-cycle core writes, and forces a hold on starvation.
module rf_host_access_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              h_req,
  input  logic              h_write,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic              h_err,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              core_rd_b,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_wba,
  input  logic [DATA_W-1:0] core_wbdata,
  input  logic [DATA_W-1:0] rf_qb,
  output logic              rf_host_b,
  output logic              rf_host_w,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              core_hold
);

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StArb, StRdCapt, StDone} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                hold_q, hold_d;
  logic                byp_q, byp_d;
  logic [DATA_W-1:0]   byp_data_q, byp_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // The core always wins the port it needs; the host only gets it on a free cycle.
  assign grant = write_q ? !core_we : !core_rd_b;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    hold_d     = 1'b0;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    rdata_d    = rdata_q;
    rf_host_b  = 1'b0;
    rf_host_w  = 1'b0;
    h_ack      = 1'b0;
    h_err      = 1'b0;

    case (state_q)
      StIdle: begin
        if (h_req) begin
          write_d = h_write;
          addr_d  = h_addr;
          wdata_d = h_wdata;
          cnt_d   = '0;
          err_d   = (32'(h_addr) >= NUM_REGS);
          state_d = err_d ? StDone : StArb;
        end
      end
      StArb: begin
        if (grant) begin
          if (write_q) begin
            rf_host_w = 1'b1;
            state_d   = StDone;
          end else begin
            rf_host_b = 1'b1;
            // RAM is not write-through: a same-cycle core write must win over stale rf_qb.
            byp_d      = core_we && (core_wba == addr_q);
            byp_data_d = core_wbdata;
            state_d    = StRdCapt;
          end
        end else begin
          if (cnt_q != MaxWaitC) cnt_d = cnt_q + 8'd1;
          hold_d = (cnt_d == MaxWaitC);
        end
      end
      StRdCapt: begin
        rdata_d = byp_q ? byp_data_q : rf_qb;
        state_d = StDone;
      end
      StDone: begin
        h_ack   = 1'b1;
        h_err   = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign h_rdata   = rdata_q;
  assign rf_addr   = addr_q;
  assign rf_wdata  = wdata_q;
  assign core_hold = hold_q;

endmodule

// File: tb/tb_rf_host_access_seq.sv
// Scoreboard bench for rf_host_access_seq: host ops against a register-file model with
// scripted core contention windows.
module tb_rf_host_access_seq;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        h_req = 1'b0, h_write = 1'b0;
  logic [5:0]  h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        h_ack, h_err;
  logic [31:0] h_rdata;
  logic        core_rd_b = 1'b0, core_we = 1'b0;
  logic [5:0]  core_wba = '0;
  logic [31:0] core_wbdata = '0;
  logic [31:0] rf_qb;
  logic        rf_host_b, rf_host_w;
  logic [5:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        core_hold;

  rf_host_access_seq #(
    .DATA_W(32), .ADDR_W(6), .NUM_REGS(32), .MAX_WAIT(8)
  ) dut (
    .clk(clk), .rst_a(rst_a),
    .h_req(h_req), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_err(h_err), .h_rdata(h_rdata),
    .core_rd_b(core_rd_b), .core_we(core_we), .core_wba(core_wba),
    .core_wbdata(core_wbdata), .rf_qb(rf_qb),
    .rf_host_b(rf_host_b), .rf_host_w(rf_host_w), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Register file model: sync port-B read, no write-through.
  logic        mem_init = 1'b1;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      mem[5] <= 32'hDEAD_BEEF;
      rf_qb  <= '0;
    end else begin
      if (rf_host_b) rf_qb <= mem[rf_addr];
      else if (core_rd_b) rf_qb <= 32'hFFFF_FFFF;
      if (core_we) mem[core_wba] <= core_wbdata;
      if (rf_host_w) mem[rf_addr] <= rf_wdata;
    end
  end

  // Core contention windows, in absolute cycles.
  int we_from = 0, we_to = 0, rdb_from = 0, rdb_to = 0;
  int we_off_from = 0, we_off_to = 0, rdb_off_from = 0, rdb_off_to = 0;
  always @(posedge clk) begin
    #2;
    core_we   = (cyc >= we_from) && (cyc < we_to);
    core_rd_b = (cyc >= rdb_from) && (cyc < rdb_to);
  end

  typedef struct {
    int          ack_cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int cnt_b = 0, cnt_w = 0, hold_first = -1, hold_last = -1, n_ack = 0, last_start = 0;

  always @(negedge clk) begin
    if (rf_host_b) cnt_b++;
    if (rf_host_w) cnt_w++;
    if (core_hold) begin
      if (hold_first < 0) hold_first = cyc;
      hold_last = cyc;
    end
    if (h_ack) begin
      exp_t e;
      n_ack++;
      check_eq("ack_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("ack_cycle", cyc, e.ack_cyc);
        check_eq("h_err", h_err, e.err);
        check_eq("h_rdata", h_rdata, e.rdata);
      end
    end
  end

  task automatic host_op(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                         input bit pulse, input int lat, input logic err,
                         input logic [31:0] exp_rd, input int exp_b, input int exp_w);
    int   start;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    start = cyc;
    last_start = start;
    cnt_b = 0; cnt_w = 0; hold_first = -1; hold_last = -1;
    we_from = start + we_off_from;   we_to = start + we_off_to;
    rdb_from = start + rdb_off_from; rdb_to = start + rdb_off_to;
    e.ack_cyc = start + lat; e.err = err; e.rdata = exp_rd;
    sb.push_back(e);
    h_req = 1'b1; h_write = wr; h_addr = addr; h_wdata = wd;
    if (pulse) begin
      @(posedge clk); #1;
      h_req = 1'b0; h_write = !wr; h_addr = '0; h_wdata = '0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = h_ack;
    end
    check_eq("ack_timeout", seen, 1);
    @(posedge clk); #1;
    h_req = 1'b0;
    check_eq("host_b_cycles", cnt_b, exp_b);
    check_eq("host_w_cycles", cnt_w, exp_w);
    we_off_from = 0; we_off_to = 0; rdb_off_from = 0; rdb_off_to = 0;
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_h_ack"}, h_ack, 0);
    check_eq({pfx, "_h_err"}, h_err, 0);
    check_eq({pfx, "_h_rdata"}, h_rdata, 0);
    check_eq({pfx, "_rf_host_b"}, rf_host_b, 0);
    check_eq({pfx, "_rf_host_w"}, rf_host_w, 0);
    check_eq({pfx, "_rf_addr"}, rf_addr, 0);
    check_eq({pfx, "_rf_wdata"}, rf_wdata, 0);
    check_eq({pfx, "_core_hold"}, core_hold, 0);
  endtask

  initial begin
    int acks_before;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst_a = 1'b1;

    // Free ports: read r5.
    host_op(1'b0, 6'd5, '0, 1'b0, 3, 1'b0, 32'hDEAD_BEEF, 1, 0);

    // Write r7 while the core writes r20 for three cycles.
    core_wba = 6'd20; core_wbdata = 32'h5555_AAAA;
    we_off_from = 0; we_off_to = 4;
    host_op(1'b1, 6'd7, 32'h1234_5678, 1'b0, 5, 1'b0, 32'hDEAD_BEEF, 0, 1);
    host_op(1'b0, 6'd7, '0, 1'b0, 3, 1'b0, 32'h1234_5678, 1, 0);
    host_op(1'b0, 6'd20, '0, 1'b0, 3, 1'b0, 32'h5555_AAAA, 1, 0);

    // Starvation: port B busy for 12 cycles.
    rdb_off_from = 0; rdb_off_to = 12;
    host_op(1'b0, 6'd5, '0, 1'b0, 14, 1'b0, 32'hDEAD_BEEF, 1, 0);
    check_eq("hold_rise", hold_first - last_start, 9);
    check_eq("hold_last", hold_last - last_start, 12);

    // Range errors.
    host_op(1'b0, 6'd40, '0, 1'b0, 1, 1'b1, 32'hDEAD_BEEF, 0, 0);
    host_op(1'b1, 6'd63, 32'h0BAD_0BAD, 1'b0, 1, 1'b1, 32'hDEAD_BEEF, 0, 0);

    // Core writes r3 in the read grant cycle.
    core_wba = 6'd3; core_wbdata = 32'hCAFE_0001;
    we_off_from = 1; we_off_to = 2;
    host_op(1'b0, 6'd3, '0, 1'b0, 3, 1'b0, 32'hCAFE_0001, 1, 0);
    host_op(1'b0, 6'd3, '0, 1'b0, 3, 1'b0, 32'hCAFE_0001, 1, 0);

    // Request dropped after one cycle still completes.
    host_op(1'b1, 6'd9, 32'hA5A5_0009, 1'b1, 2, 1'b0, 32'hCAFE_0001, 0, 1);
    host_op(1'b0, 6'd9, '0, 1'b0, 3, 1'b0, 32'hA5A5_0009, 1, 0);

    // Reset while starved in ARB.
    @(posedge clk); #1;
    rdb_from = cyc; rdb_to = cyc + 1000;
    h_req = 1'b1; h_write = 1'b0; h_addr = 6'd5;
    for (int i = 0; i < 40 && !core_hold; i++) @(negedge clk);
    check_eq("hold_before_reset", core_hold, 1);
    @(posedge clk); #3;
    rst_a = 1'b0;
    #1;
    check_quiet("midreset");
    h_req = 1'b0;
    sb.delete();
    rdb_to = 0;
    acks_before = n_ack;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("no_ack_after_reset", n_ack, acks_before);
    check_eq("rdata_after_reset", h_rdata, 0);

    host_op(1'b0, 6'd7, '0, 1'b0, 3, 1'b0, 32'h1234_5678, 1, 0);
    check_eq("sb_drained", sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
